// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one combinational sll/sra shifter pair.
//   Round-robin grant feeds the shifter, and the selected result is captured into one
//   registered response slot that carries the owning port tag.
//   Ports:
//     clock/reset       rising-edge clock, synchronous active-high reset
//     reqN_*            valid/ready request with operand, shamt and op (0 = sll, 1 = sra)
//     sh_*              operand/shamt out to the shifter pair, sll/sra results back
//     rsp_*             valid/ready response with result data and requester index
//   Build option: define SHIFT_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins
//   contention, port 1 may starve); round-robin by default.
module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [SHW-1:0]   req0_shamt,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [SHW-1:0]   req1_shamt,
  input  logic             req1_op,
  output logic [WIDTH-1:0] sh_operand,
  output logic [SHW-1:0]   sh_shamt,
  input  logic [WIDTH-1:0] sh_sll_result,
  input  logic [WIDTH-1:0] sh_sra_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_port
);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             port_q, port_d;
  logic             can_accept, accept, grant;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign grant = req1_valid && !req0_valid;
`else
  logic last_q, last_d;
  // On contention the port that did not win last time goes next.
  assign grant  = (req0_valid && req1_valid) ? !last_q : req1_valid;
  assign last_d = accept ? grant : last_q;
  always_ff @(posedge clock) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`endif
  // Nothing is accepted in the reset cycle; the slot frees up when it is drained.
  assign can_accept = !reset && (!rsp_valid || rsp_ready);
  assign accept     = can_accept && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  // With no request the mux rests on port 0, so the shifter never sees X.
  assign sh_operand = grant ? req1_data : req0_data;
  assign sh_shamt   = grant ? req1_shamt : req0_shamt;
  assign rsp_valid  = state_q == FULL;
  assign rsp_data   = data_q;
  assign rsp_port   = port_q;
  always_comb begin
    state_d = accept ? FULL : (rsp_ready ? EMPTY : state_q);
    data_d  = accept ? ((grant ? req1_op : req0_op) ? sh_sra_result : sh_sll_result) : data_q;
    port_d  = accept ? grant : port_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      port_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      port_q  <= port_d;
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed and randomized checks of shift_arbiter against a behavioural model
module tb_shift_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_op = 1'b0, req1_op = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic [4:0]  req0_shamt = '0, req1_shamt = '0;
  logic [31:0] sh_operand, sh_sll_result, sh_sra_result;
  logic [4:0]  sh_shamt;
  logic        rsp_valid, rsp_port;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  int          checks = 0;
  int          errors = 0;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  always #5 clock = ~clock;

  assign sh_sll_result = sh_operand << sh_shamt;
  assign sh_sra_result = $unsigned($signed(sh_operand) >>> sh_shamt);

  shift_arbiter #(.WIDTH(32), .SHW(5)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .sh_operand(sh_operand), .sh_shamt(sh_shamt),
    .sh_sll_result(sh_sll_result), .sh_sra_result(sh_sra_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_port(rsp_port)
  );

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic op);
    logic [63:0] ext;
    ext = op ? ({{32{d[31]}}, d} >> s) : ({32'b0, d} * (64'd1 << s));
    return ext[31:0];
  endfunction

  logic        m_valid, m_port, m_last, m_win, m_can, m_any, exp_r0, exp_r1;
  logic [31:0] m_data;
  assign m_any  = req0_valid || req1_valid;
  assign m_win  = (req0_valid && req1_valid) ? (FIXED ? 1'b0 : !m_last) : req1_valid;
  assign m_can  = !reset && (!m_valid || rsp_ready);
  assign exp_r0 = m_can && m_any && !m_win;
  assign exp_r1 = m_can && m_any && m_win;

  always @(posedge clock) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_port  <= 1'b0;
      m_last  <= 1'b1;
    end else if (m_can && m_any) begin
      m_valid <= 1'b1;
      m_data  <= m_win ? ref_shift(req1_data, req1_shamt, req1_op) : ref_shift(req0_data, req0_shamt, req0_op);
      m_port  <= m_win;
      m_last  <= m_win;
    end else if (rsp_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic drive(input logic rst, v0, v1, input logic [31:0] d0, d1,
                       input logic [4:0] s0, s1, input logic o0, o1, rr);
    @(negedge clock);
    reset = rst; req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
    req0_shamt = s0; req1_shamt = s1; req0_op = o0; req1_op = o1; rsp_ready = rr;
    #1;
  endtask

  task automatic test_reset;
    drive(1, 1, 1, '1, '1, 3, 3, 0, 1, 1);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b exp 00", {req1_ready, req0_ready});
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if ({rsp_valid, rsp_port, rsp_data} !== 34'b0) begin
      errors++; $display("FAIL reset_state: got valid=%b port=%b data=%h exp 0/0/0", rsp_valid, rsp_port, rsp_data);
    end
  endtask

  task automatic test_directed;
    drive(0, 1, 0, 32'h1, 0, 4, 0, 0, 0, 1);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL dir_ready0: got %b exp 01", {req1_ready, req0_ready});
    end
    drive(0, 0, 1, 0, 32'h8000_0000, 0, 31, 0, 1, 1);
    checks++;
    if ({rsp_valid, rsp_port, rsp_data} !== {1'b1, 1'b0, 32'h10}) begin
      errors++; $display("FAIL dir_sll4: got valid=%b port=%b data=%h exp 1/0/00000010", rsp_valid, rsp_port, rsp_data);
    end
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL dir_ready1: got %b exp 1", req1_ready);
    end
    drive(0, 0, 1, 0, 32'h8000_0000, 0, 1, 0, 0, 1);
    checks++;
    if ({rsp_valid, rsp_port, rsp_data} !== {1'b1, 1'b1, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL dir_sra31: got valid=%b port=%b data=%h exp 1/1/ffffffff", rsp_valid, rsp_port, rsp_data);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if ({rsp_valid, rsp_port, rsp_data} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL dir_sll1: got valid=%b port=%b data=%h exp 1/1/00000000", rsp_valid, rsp_port, rsp_data);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL dir_drain: got valid=%b exp 0", rsp_valid);
    end
  endtask

  task automatic test_shamt_zero;
    for (int p = 0; p < 2; p++)
      for (int o = 0; o < 2; o++) begin
        drive(0, p == 0, p == 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, o[0], o[0], 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({rsp_valid, rsp_port, rsp_data} !== {1'b1, p[0], 32'hDEAD_BEEF}) begin
          errors++; $display("FAIL shamt0 p%0d op%0d: got valid=%b port=%b data=%h exp 1/%0d/deadbeef",
                             p, o, rsp_valid, rsp_port, rsp_data, p);
        end
      end
  endtask

  task automatic test_fairness;
    logic [31:0] d0, d1;
    logic [4:0]  s0, s1;
    logic        o0, o1;
    d0 = $urandom; d1 = $urandom; s0 = 5'($urandom_range(0, 31)); s1 = 5'($urandom_range(0, 31));
    o0 = 1'($urandom_range(0, 1)); o1 = 1'($urandom_range(0, 1));
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i <= 6; i++) begin
      drive(0, i < 6, i < 6, d0, d1, s0, s1, o0, o1, 1);
      if (i > 0) begin
        logic pe;
        pe = FIXED ? 1'b0 : 1'((i - 1) % 2);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_port !== pe || rsp_data !== (pe ? ref_shift(d1, s1, o1) : ref_shift(d0, s0, o0))) begin
          errors++; $display("FAIL fair_rsp%0d: got valid=%b port=%b data=%h exp port=%b", i - 1, rsp_valid, rsp_port, rsp_data, pe);
        end
      end
      if (i < 6) begin
        logic ge;
        ge = FIXED ? 1'b0 : 1'(i % 2);
        checks++;
        if ({req1_ready, req0_ready} !== (ge ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL fair_ready%0d: got %b exp %b", i, {req1_ready, req0_ready}, ge ? 2'b10 : 2'b01);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d0, d1, hold;
    d0 = $urandom; d1 = $urandom;
    hold = '0;
    drive(0, 1, 1, d0, d1, 3, 7, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, d0, d1, 3, 7, 0, 1, 0);
      if (k == 0) hold = m_data;
      checks++;
      if (rsp_valid !== 1'b1 || {req1_ready, req0_ready} !== 2'b00 || rsp_data !== hold) begin
        errors++; $display("FAIL bp_hold%0d: got valid=%b ready=%b data=%h exp 1/00/%h",
                           k, rsp_valid, {req1_ready, req0_ready}, rsp_data, hold);
      end
    end
    drive(0, 1, 1, d0, d1, 3, 7, 0, 1, 1);
    checks++;
    if (rsp_valid !== 1'b1 || (req0_ready ^ req1_ready) !== 1'b1) begin
      errors++; $display("FAIL bp_release: got valid=%b ready=%b exp 1/onehot", rsp_valid, {req1_ready, req0_ready});
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== m_data || rsp_port !== m_port) begin
      errors++; $display("FAIL bp_replace: got valid=%b port=%b data=%h exp 1/%b/%h", rsp_valid, rsp_port, rsp_data, m_port, m_data);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    drive(0, 1, 1, d0, d1, 9, 2, 1, 0, 0);
    drive(0, 1, 1, d0, d1, 9, 2, 1, 0, 0);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rm_full: got valid=%b exp 1", rsp_valid);
    end
    drive(1, 1, 1, d0, d1, 9, 2, 1, 0, 1);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++; $display("FAIL rm_ready_in_reset: got %b exp 00", {req1_ready, req0_ready});
    end
    drive(0, 1, 1, d0, d1, 9, 2, 1, 0, 1);
    checks++;
    if (rsp_valid !== 1'b0 || {req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL rm_after: got valid=%b ready=%b exp 0/01", rsp_valid, {req1_ready, req0_ready});
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if ({rsp_valid, rsp_port, rsp_data} !== {1'b1, 1'b0, ref_shift(d0, 9, 1)}) begin
      errors++; $display("FAIL rm_first: got valid=%b port=%b data=%h exp 1/0/%h", rsp_valid, rsp_port, rsp_data, ref_shift(d0, 9, 1));
    end
  endtask

  task automatic test_random;
    logic        v0, v1, o0, o1, a0, a1, rr, rst;
    logic [31:0] d0, d1;
    logic [4:0]  s0, s1;
    v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; s0 = 0; s1 = 0; o0 = 0; o1 = 0;
    for (int n = 0; n < 600; n++) begin
      if (!v0 || a0) begin
        v0 = $urandom_range(0, 2) != 0; d0 = $urandom; s0 = 5'($urandom_range(0, 31)); o0 = 1'($urandom_range(0, 1));
      end
      if (!v1 || a1) begin
        v1 = $urandom_range(0, 2) != 0; d1 = $urandom; s1 = 5'($urandom_range(0, 31)); o1 = 1'($urandom_range(0, 1));
      end
      rr  = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 63) == 0;
      drive(rst, v0, v1, d0, d1, s0, s1, o0, o1, rr);
      checks++;
      if (rsp_valid !== m_valid || rsp_data !== m_data || rsp_port !== m_port) begin
        errors++; $display("FAIL rnd_rsp%0d: got %b/%b/%h exp %b/%b/%h", n, rsp_valid, rsp_port, rsp_data, m_valid, m_port, m_data);
      end
      checks++;
      if ({req1_ready, req0_ready} !== {exp_r1, exp_r0}) begin
        errors++; $display("FAIL rnd_ready%0d: got %b exp %b", n, {req1_ready, req0_ready}, {exp_r1, exp_r0});
      end
      checks++;
      if ($isunknown(sh_operand) || (m_any && sh_operand !== (m_win ? d1 : d0))) begin
        errors++; $display("FAIL rnd_operand%0d: got %h exp %h", n, sh_operand, m_win ? d1 : d0);
      end
      a0 = exp_r0;
      a1 = exp_r1;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_shamt_zero;
    test_fairness;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
